// File: rtl/fetch_sequencer_if.sv
// Program-memory fetch bus between the sequencer (master) and program memory (slave).
// Memory answers a request with prog_ready and the 16-bit word on prog_data.
interface fetch_sequencer_if #(
  parameter int PC_W = 12
);
  logic            prog_req;
  logic [PC_W-1:0] prog_addr;
  logic            prog_ready;
  logic [15:0]     prog_data;

  modport master (
    output prog_req,
    output prog_addr,
    input  prog_ready,
    input  prog_data
  );

  modport slave (
    input  prog_req,
    input  prog_addr,
    output prog_ready,
    output prog_data
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction sequencer: owns PC, IR and flags, fetches words over a ready/request bus,
// drives the decoder phase and adds run/step/halt control with a sticky fetch-timeout error.
module fetch_sequencer #(
  parameter int PC_W    = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  fetch_sequencer_if.master bus,
  input  logic              incPC,
  input  logic              loadPC,
  input  logic              loadFlags,
  input  logic              alu_c,
  input  logic              alu_z,
  output logic              phase,
  output logic [3:0]        instr,
  output logic [3:0]        oprnd,
  output logic              c_flag,
  output logic              z_flag,
  output logic [PC_W-1:0]   pc,
  output logic              exec_en,
  output logic              busy,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2
  } stateT;

  stateT           stateR, nextStateS;
  logic [PC_W-1:0] pcR, pcS;
  logic [15:0]     irR, irS;
  logic [7:0]      waitR, waitS;
  logic            cR, cS, zR, zS;
  logic            errR, errS;
  logic            singleR, singleS;
  logic            phaseR, reqR, execR, busyR;

  // Next-state and next-register decode for HALTED / FETCH / EXEC.
  always_comb begin
    nextStateS = stateR;
    pcS        = pcR;
    irS        = irR;
    waitS      = waitR;
    cS         = cR;
    zS         = zR;
    errS       = errR;
    singleS    = singleR;
    case (stateR)
      HALTED: begin
        if (errR) begin
          nextStateS = HALTED;
        end else if (run) begin
          nextStateS = FETCH;
          singleS    = 1'b0;
        end else if (step) begin
          nextStateS = FETCH;
          singleS    = 1'b1;
        end else begin
          nextStateS = HALTED;
        end
      end
      FETCH: begin
        // Ready on the last window cycle is still accepted; the timeout only fires without it.
        if (bus.prog_ready) begin
          irS        = bus.prog_data;
          waitS      = 8'd0;
          nextStateS = EXEC;
        end else if (waitR == 8'(TIMEOUT)) begin
          errS       = 1'b1;
          waitS      = 8'd0;
          nextStateS = HALTED;
        end else begin
          waitS      = waitR + 8'd1;
        end
      end
      EXEC: begin
        if (loadPC) begin
          pcS = PC_W'(irR[11:0]);
        end else if (incPC) begin
          pcS = pcR + PC_W'(1);
        end else begin
          pcS = pcR;
        end
        if (loadFlags) begin
          cS = alu_c;
          zS = alu_z;
        end else begin
          cS = cR;
          zS = zR;
        end
        if (run && !singleR) begin
          nextStateS = FETCH;
        end else begin
          nextStateS = HALTED;
        end
      end
      default: begin
        nextStateS = HALTED;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateR <= HALTED;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Datapath registers; status outputs are registered from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcR     <= '0;
      irR     <= 16'd0;
      waitR   <= 8'd0;
      cR      <= 1'b0;
      zR      <= 1'b0;
      errR    <= 1'b0;
      singleR <= 1'b0;
      phaseR  <= 1'b0;
      reqR    <= 1'b0;
      execR   <= 1'b0;
      busyR   <= 1'b0;
    end else begin
      pcR     <= pcS;
      irR     <= irS;
      waitR   <= waitS;
      cR      <= cS;
      zR      <= zS;
      errR    <= errS;
      singleR <= singleS;
      phaseR  <= (nextStateS == EXEC);
      reqR    <= (nextStateS == FETCH);
      execR   <= (nextStateS == EXEC);
      busyR   <= (nextStateS != HALTED);
    end
  end

  assign bus.prog_req  = reqR;
  assign bus.prog_addr = pcR;
  assign pc            = pcR;
  assign instr         = irR[15:12];
  assign oprnd         = irR[11:8];
  assign c_flag        = cR;
  assign z_flag        = zR;
  assign phase         = phaseR;
  assign exec_en       = execR;
  assign busy          = busyR;
  assign bus_err       = errR;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed steps plus randomized instructions
// checked against an instruction-level reference model (PC, flags, IR expectations).
module tb_fetch_sequencer;
  localparam int PC_W    = 12;
  localparam int TIMEOUT = 15;

  logic            clock = 1'b0;
  logic            reset, run, step;
  logic            incPC, loadPC, loadFlags, alu_c, alu_z;
  logic            phase, c_flag, z_flag, exec_en, busy, bus_err;
  logic [3:0]      instr, oprnd;
  logic [PC_W-1:0] pc;

  int checks = 0;
  int fails  = 0;
  int mPc;
  bit mC, mZ, mStep;

  fetch_sequencer_if #(.PC_W(PC_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .run(run), .step(step), .bus(bus),
    .incPC(incPC), .loadPC(loadPC), .loadFlags(loadFlags), .alu_c(alu_c), .alu_z(alu_z),
    .phase(phase), .instr(instr), .oprnd(oprnd), .c_flag(c_flag), .z_flag(z_flag),
    .pc(pc), .exec_en(exec_en), .busy(busy), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expectIdle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".req"}, 32'(bus.prog_req), 32'd0);
    chk({tag, ".phase"}, 32'(phase), 32'd0);
    chk({tag, ".exec_en"}, 32'(exec_en), 32'd0);
  endtask

  task automatic expectFetch(input string tag);
    chk({tag, ".req"}, 32'(bus.prog_req), 32'd1);
    chk({tag, ".phase"}, 32'(phase), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".exec_en"}, 32'(exec_en), 32'd0);
    chk({tag, ".addr"}, 32'(bus.prog_addr), 32'(mPc));
  endtask

  // One instruction from a FETCH cycle: 'delay' not-ready cycles, then ready, then EXEC.
  task automatic doInstr(input logic [15:0] word, input int delay,
                         input bit inc, input bit ld, input bit lf, input bit ac, input bit az,
                         input bit dropRun, input bit stepInExec);
    incPC = inc; loadPC = ld; loadFlags = lf; alu_c = ac; alu_z = az;
    for (int d = 0; d < delay; d++) begin
      bus.prog_ready = 1'b0;
      bus.prog_data  = 16'($urandom);
      expectFetch("wait");
      chk("wait.pc", 32'(pc), 32'(mPc));
      chk("wait.bus_err", 32'(bus_err), 32'd0);
      if (dropRun && d == 0) run = 1'b0;
      tick();
    end
    bus.prog_ready = 1'b1;
    bus.prog_data  = word;
    expectFetch("fetch");
    if (dropRun && delay == 0) run = 1'b0;
    tick();
    bus.prog_ready = 1'b0;
    bus.prog_data  = 16'($urandom);
    chk("exec.phase", 32'(phase), 32'd1);
    chk("exec.exec_en", 32'(exec_en), 32'd1);
    chk("exec.req", 32'(bus.prog_req), 32'd0);
    chk("exec.busy", 32'(busy), 32'd1);
    chk("exec.instr", 32'(instr), 32'(word[15:12]));
    chk("exec.oprnd", 32'(oprnd), 32'(word[11:8]));
    chk("exec.pc", 32'(pc), 32'(mPc));
    chk("exec.c", 32'(c_flag), 32'(mC));
    chk("exec.z", 32'(z_flag), 32'(mZ));
    step = stepInExec;
    tick();
    step = 1'b0;
    if (ld) mPc = int'(word[11:0]);
    else if (inc) mPc = (mPc + 1) % 4096;
    if (lf) begin
      mC = ac;
      mZ = az;
    end
    chk("post.pc", 32'(pc), 32'(mPc));
    chk("post.c", 32'(c_flag), 32'(mC));
    chk("post.z", 32'(z_flag), 32'(mZ));
    chk("post.bus_err", 32'(bus_err), 32'd0);
    if (run && !mStep) expectFetch("next");
    else expectIdle("halt");
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b1; run = 1'b0; step = 1'b0;
    incPC = 1'b0; loadPC = 1'b0; loadFlags = 1'b0; alu_c = 1'b0; alu_z = 1'b0;
    bus.prog_ready = 1'b0; bus.prog_data = 16'h0000;
    mPc = 0; mC = 1'b0; mZ = 1'b0; mStep = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst.pc", 32'(pc), 32'd0);
    chk("rst.instr", 32'(instr), 32'd0);
    chk("rst.oprnd", 32'(oprnd), 32'd0);
    chk("rst.c", 32'(c_flag), 32'd0);
    chk("rst.z", 32'(z_flag), 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    expectIdle("rst");
    tick();
    expectIdle("idle");

    // Straight-line run, incPC held in both phases.
    run = 1'b1;
    tick();
    expectFetch("start");
    doInstr(16'h4500, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    doInstr(16'hA300, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("line.addr2", 32'(bus.prog_addr), 32'd2);

    // Jump at pc 5, then loadPC together with incPC.
    for (int i = 0; i < 3; i++) doInstr(16'h1000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jump.pc5", 32'(pc), 32'd5);
    doInstr(16'hC123, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jump.addr", 32'(bus.prog_addr), 32'h123);
    doInstr(16'hC123, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jump.both", 32'(pc), 32'h123);

    // Wait states and ready on the last window cycle.
    doInstr(16'h7A55, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    doInstr(16'h2BCD, TIMEOUT, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Randomized instruction stream.
    for (int i = 0; i < 24; i++) begin
      w = 16'($urandom);
      doInstr(w, $urandom_range(0, TIMEOUT), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'b0, 1'b0);
    end

    // PC wrap with flag load; run dropped during FETCH.
    doInstr(16'hCFFF, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap.pcFFF", 32'(pc), 32'hFFF);
    doInstr(16'h5000, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("wrap.pc0", 32'(pc), 32'd0);
    chk("wrap.c", 32'(c_flag), 32'd1);
    chk("wrap.z", 32'(z_flag), 32'd0);
    tick();
    expectIdle("stopped");

    // Single step, with a stray step pulse during EXEC.
    step = 1'b1; mStep = 1'b1;
    tick();
    step = 1'b0;
    expectFetch("step");
    doInstr(16'h3000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expectIdle("stepHold");
    end
    chk("step.pc", 32'(pc), 32'd1);
    mStep = 1'b0;

    // Reset in the middle of EXEC.
    run = 1'b1;
    tick();
    bus.prog_ready = 1'b1; bus.prog_data = 16'hF7AB;
    tick();
    bus.prog_ready = 1'b0;
    chk("mid.instr", 32'(instr), 32'hF);
    reset = 1'b1; incPC = 1'b1; loadFlags = 1'b1; alu_c = 1'b1; alu_z = 1'b1;
    tick();
    reset = 1'b0;
    mPc = 0; mC = 1'b0; mZ = 1'b0;
    chk("mid.pc", 32'(pc), 32'd0);
    chk("mid.instr0", 32'(instr), 32'd0);
    chk("mid.oprnd0", 32'(oprnd), 32'd0);
    chk("mid.c", 32'(c_flag), 32'd0);
    chk("mid.z", 32'(z_flag), 32'd0);
    expectIdle("mid");

    // Fetch timeout: 16 not-ready FETCH cycles, then sticky error.
    tick();
    expectFetch("toStart");
    doInstr(16'h1E00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.prog_ready = 1'b0;
    for (int i = 0; i <= TIMEOUT; i++) begin
      expectFetch("toWait");
      chk("toWait.bus_err", 32'(bus_err), 32'd0);
      tick();
    end
    chk("to.bus_err", 32'(bus_err), 32'd1);
    chk("to.pc", 32'(pc), 32'd1);
    chk("to.instr", 32'(instr), 32'h1);
    expectIdle("to");
    for (int i = 0; i < 5; i++) begin
      step = 1'(i % 2);
      tick();
      expectIdle("toLocked");
      chk("toLocked.bus_err", 32'(bus_err), 32'd1);
    end
    step = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mPc = 0;
    chk("clr.bus_err", 32'(bus_err), 32'd0);
    chk("clr.pc", 32'(pc), 32'd0);
    tick();
    expectFetch("restart");
    doInstr(16'h6100, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("restart.pc", 32'(pc), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
